// File: rtl/multicycle_control.sv
// Multicycle MIPS main controller (Moore FSM) with built-in ALU decoder.
// Latency: lw 5, sw/R-type/addi 4, beq/j 3 cycles, +1 per memory wait cycle.
// Backpressure: FETCH, MEMRD and MEMWR hold their state until MemReady is high.
module multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  input  logic               MemReady,
  output logic               MemReq,
  output logic               MemWrite,
  output logic               IorD,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [1:0]         PCSrc,
  output logic               PCEn,
  output logic               IllegalOp,
  output logic [STATE_W-1:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t     state;
  state_t     state_nxt;
  logic       funct_ok;
  logic [2:0] funct_alu;

  assign State = STATE_W'(state);

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= state_nxt;
  end

  // R-type function decode: ALU operation and whether the Funct is supported.
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = 3'd0;
    case (Funct)
      6'b100000: funct_alu = 3'd2;
      6'b100010: funct_alu = 3'd6;
      6'b100100: funct_alu = 3'd0;
      6'b100101: funct_alu = 3'd1;
      6'b101010: funct_alu = 3'd7;
      default:   funct_ok  = 1'b0;
    endcase
  end

  // Next-state and output decode; write enables are squashed while in reset.
  always_comb begin
    state_nxt  = S_FETCH;
    MemReq     = 1'b0;
    MemWrite   = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 3'd0;
    PCSrc      = 2'b00;
    PCEn       = 1'b0;
    IllegalOp  = 1'b0;
    case (state)
      S_FETCH: begin
        MemReq     = 1'b1;
        ALUSrcB    = 2'b01;
        ALUControl = 3'd2;
        IRWrite    = MemReady;
        PCEn       = MemReady;
        state_nxt  = MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is precomputed here so BRANCH can load it from ALUOut.
        ALUSrcB    = 2'b11;
        ALUControl = 3'd2;
        case (Op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYP:      state_nxt = S_EXECUTE;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_ADDI:      state_nxt = S_ADDIEXEC;
          OP_J:         state_nxt = S_JUMP;
          default: begin
            IllegalOp = 1'b1;
            state_nxt = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = 3'd2;
        state_nxt  = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemReq    = 1'b1;
        IorD      = 1'b1;
        state_nxt = MemReady ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        MemReq    = 1'b1;
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        state_nxt = MemReady ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = funct_alu;
        IllegalOp  = ~funct_ok;
        state_nxt  = funct_ok ? S_ALUWB : S_FETCH;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = 3'd6;
        PCSrc      = 2'b01;
        PCEn       = Zero;
      end
      S_ADDIEXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = 3'd2;
        state_nxt  = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
      end
      S_JUMP: begin
        PCSrc = 2'b10;
        PCEn  = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
    if (!reset_n) begin
      MemReq    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      PCEn      = 1'b0;
      RegWrite  = 1'b0;
      IllegalOp = 1'b0;
    end
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle MIPS main controller with built-in ALU decoder.
- It drives ALUControl into the datapath ALU and consumes the ALU's Zero flag for branch resolution.
- Sequences fetch/decode/execute/memory/writeback through a Moore FSM and waits on a memory ready handshake.
- Supports lw, sw, R-type (add, sub, and, or, slt), beq, addi and j.

Parameters:
- STATE_W, 4, width of the state register and of the State debug port.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- Op  in  6  opcode field (Instr[31:26]) from the instruction register
- Funct  in  6  function field (Instr[5:0]) from the instruction register
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory completes the current access this cycle
- MemReq  out  1  memory access request
- MemWrite  out  1  write strobe, qualifies MemReq
- IorD  out  1  address select: 0 = PC, 1 = ALUOut
- IRWrite  out  1  instruction register load
- RegDst  out  1  register destination: 0 = rt, 1 = rd
- MemtoReg  out  1  writeback select: 0 = ALUOut, 1 = Data
- RegWrite  out  1  register file write
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = A
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- ALUControl  out  3  ALU operation: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT
- PCSrc  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- PCEn  out  1  PC load = PCWrite | (Branch & Zero)
- IllegalOp  out  1  one-cycle flag for an unsupported Op or Funct
- State  out  STATE_W  current state, for debug

Behaviour:
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11. Codes 12-15 go to FETCH on the next edge.
- Reset: reset_n low forces State = FETCH immediately (asynchronous). While reset_n is low, all write enables (IRWrite, PCEn, MemWrite, RegWrite, MemReq) and IllegalOp are forced to 0. Mux selects show FETCH values. Reset mid-instruction abandons the instruction with no further writes.
- Outputs are Moore, decoded from the state only, except:
  - IRWrite and PCEn in FETCH, which equal MemReady;
  - PCEn in BRANCH, which equals Zero;
  - IllegalOp.
- Outputs not listed for a state are 0, including ALUControl = 0.
- FETCH:
  - Outputs: MemReq = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUControl = 2, PCSrc = 00, IRWrite = PCEn = MemReady.
  - Next: hold while MemReady = 0; go to DECODE on MemReady = 1.
- DECODE:
  - Outputs: ALUSrcA = 0, ALUSrcB = 11, ALUControl = 2 (branch target into ALUOut).
  - Next by Op: 100011 or 101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEXEC; 000010 -> JUMP.
  - Any other Op -> FETCH with IllegalOp = 1 for this cycle.
- MEMADR:
  - Outputs: ALUSrcA = 1, ALUSrcB = 10, ALUControl = 2.
  - Next: Op 100011 -> MEMRD, else MEMWR.
- MEMRD:
  - Outputs: MemReq = 1, IorD = 1.
  - Next: hold until MemReady, then MEMWB.
- MEMWB:
  - Outputs: RegDst = 0, MemtoReg = 1, RegWrite = 1.
  - Next: FETCH.
- MEMWR:
  - Outputs: MemReq = 1, MemWrite = 1, IorD = 1.
  - Next: hold until MemReady, then FETCH.
- EXECUTE:
  - Outputs: ALUSrcA = 1, ALUSrcB = 00. ALUControl by Funct: 100000 -> 2, 100010 -> 6, 100100 -> 0, 100101 -> 1, 101010 -> 7.
  - Next: ALUWB for a supported Funct.
  - Unsupported Funct: ALUControl = 0, IllegalOp = 1, next FETCH, no writeback.
- ALUWB:
  - Outputs: RegDst = 1, MemtoReg = 0, RegWrite = 1.
  - Next: FETCH.
- BRANCH:
  - Outputs: ALUSrcA = 1, ALUSrcB = 00, ALUControl = 6, PCSrc = 01, PCEn = Zero.
  - Next: FETCH.
- ADDIEXEC:
  - Outputs: ALUSrcA = 1, ALUSrcB = 10, ALUControl = 2.
  - Next: ADDIWB.
- ADDIWB:
  - Outputs: RegDst = 0, MemtoReg = 0, RegWrite = 1.
  - Next: FETCH.
- JUMP:
  - Outputs: PCSrc = 10, PCEn = 1.
  - Next: FETCH.
- Op and Funct are sampled combinationally and must be stable from DECODE until the instruction completes. MemReady is ignored outside FETCH, MEMRD and MEMWR.
- Latency with MemReady held at 1: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each added wait cycle at FETCH, MEMRD or MEMWR extends the instruction by 1.

Test Plan:
- reset_n low mid-MEMRD, then high with MemReady = 1 -> State = 0 immediately on assertion. No RegWrite is seen. Next cycle shows IRWrite = 1, PCEn = 1.
- lw (Op = 100011), MemReady = 1 -> States 0, 1, 2, 3, 4, 0. Exactly one RegWrite = 1 cycle, with MemtoReg = 1 and RegDst = 0.
- R-type: Op = 000000 with Funct = 101010 -> EXECUTE shows ALUControl = 7, then ALUWB with RegDst = 1, RegWrite = 1. Funct = 100010 -> EXECUTE shows ALUControl = 6.
- beq (Op = 000100), Zero = 1 and then Zero = 0 -> in BRANCH, PCEn = 1 with PCSrc = 01 when Zero = 1, and PCEn = 0 when Zero = 0. Both cases take 3 cycles.
- sw with MemReady low for 3 cycles in MEMWR -> MemReq = MemWrite = 1 held for 4 cycles, then FETCH. RegWrite is never asserted.
- Op = 111111 in DECODE -> IllegalOp = 1 for one cycle, next State = 0. Funct = 000000 in EXECUTE -> IllegalOp = 1, ALUControl = 0, no ALUWB.
